// File: rtl/color_centroid.sv
// rtl/color_centroid.sv - horizontal centroid band and size level of colour-matched pixels
// One result per 80x60 RGB444 frame; division is restoring, one quotient bit per cycle.
module color_centroid #(
    parameter int c_img_cols  = 80,
    parameter int c_img_rows  = 60,
    parameter int c_nb_cols   = 7,
    parameter int c_nb_rows   = 6,
    parameter int c_nb_cnt    = 13,
    parameter int c_nb_sum    = 20,
    parameter int c_band_cols = 10,
    parameter int c_thr       = 8,
    parameter int c_min_pxls  = 16,
    parameter int c_prox_step = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pxl_valid,
    input  logic [11:0] pxl_data,
    input  logic [2:0]  rgbfilter,
    output logic [7:0]  centroid,
    output logic [2:0]  proximity,
    output logic        centroid_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DIVIDE = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [c_nb_cols-1:0]  col_q, col_d;
    logic [c_nb_rows-1:0]  row_q, row_d;
    logic [c_nb_cnt-1:0]   count_q, count_d;
    logic [c_nb_sum-1:0]   sum_q, sum_d;
    logic [c_nb_cnt-1:0]   rem_q, rem_d;
    logic [4:0]            div_cnt_q, div_cnt_d;
    logic [7:0]            centroid_q, centroid_d;
    logic [2:0]            proximity_q, proximity_d;
    logic                  centroid_valid_q, centroid_valid_d;

    logic                  clr_cnt, acc_en, div_en, upd_en;
    logic                  pxl_match, last_col, last_pxl, div_done;
    logic [c_nb_cnt:0]     rem_shift;
    logic                  q_bit;
    logic [c_nb_sum-1:0]   avg;
    logic [2:0]            band;
    logic [2:0]            prox;

    assign pxl_match = ({pxl_data[11:8] >= 4'(c_thr),
                         pxl_data[7:4]  >= 4'(c_thr),
                         pxl_data[3:0]  >= 4'(c_thr)} == rgbfilter);
    assign last_col  = (col_q == c_nb_cols'(c_img_cols - 1));
    assign last_pxl  = last_col && (row_q == c_nb_rows'(c_img_rows - 1));
    assign div_done  = (div_cnt_q == 5'(c_nb_sum - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (frame_start) state_d = S_ACCUM;
            S_ACCUM:  if (!frame_start && pxl_valid && last_pxl) state_d = S_DIVIDE;
            S_DIVIDE: if (div_done) state_d = S_UPDATE;
            S_UPDATE: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    // frame_start wins over a simultaneous pixel, which is dropped
    always_comb begin
        clr_cnt = 1'b0;
        acc_en  = 1'b0;
        div_en  = 1'b0;
        upd_en  = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_WAIT:   clr_cnt = frame_start;
            S_ACCUM: begin
                clr_cnt = frame_start;
                acc_en  = pxl_valid && !frame_start;
            end
            S_DIVIDE: begin
                div_en = 1'b1;
                busy   = 1'b1;
            end
            S_UPDATE: begin
                upd_en = 1'b1;
                busy   = 1'b1;
            end
            default: ;
        endcase
    end

    // sum_q doubles as dividend/quotient shift register during DIVIDE
    always_comb begin
        rem_shift = {rem_q, sum_q[c_nb_sum-1]};
        q_bit     = (rem_shift >= {1'b0, count_q});
    end

    always_comb begin
        avg = (count_q == '0) ? '0 : sum_q;
        band = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (avg >= c_nb_sum'(i * c_band_cols)) band = 3'(i);
        end
        prox = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (count_q >= c_nb_cnt'(i * c_prox_step)) prox = 3'(i);
        end
    end

    always_comb begin
        col_d            = col_q;
        row_d            = row_q;
        count_d          = count_q;
        sum_d            = sum_q;
        rem_d            = rem_q;
        div_cnt_d        = div_cnt_q;
        centroid_d       = centroid_q;
        proximity_d      = proximity_q;
        centroid_valid_d = 1'b0;
        if (clr_cnt) begin
            col_d     = '0;
            row_d     = '0;
            count_d   = '0;
            sum_d     = '0;
            rem_d     = '0;
            div_cnt_d = '0;
        end else if (acc_en) begin
            if (pxl_match) begin
                count_d = count_q + c_nb_cnt'(1);
                sum_d   = sum_q + c_nb_sum'(col_q);
            end
            if (last_col) begin
                col_d = '0;
                row_d = last_pxl ? '0 : row_q + c_nb_rows'(1);
            end else begin
                col_d = col_q + c_nb_cols'(1);
            end
        end else if (div_en) begin
            rem_d     = q_bit ? c_nb_cnt'(rem_shift - {1'b0, count_q}) : c_nb_cnt'(rem_shift);
            sum_d     = {sum_q[c_nb_sum-2:0], q_bit};
            div_cnt_d = div_cnt_q + 5'd1;
        end else if (upd_en) begin
            centroid_d       = (count_q >= c_nb_cnt'(c_min_pxls)) ? (8'b1 << band) : 8'b0;
            proximity_d      = prox;
            centroid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q            <= '0;
            row_q            <= '0;
            count_q          <= '0;
            sum_q            <= '0;
            rem_q            <= '0;
            div_cnt_q        <= '0;
            centroid_q       <= '0;
            proximity_q      <= '0;
            centroid_valid_q <= 1'b0;
        end else begin
            col_q            <= col_d;
            row_q            <= row_d;
            count_q          <= count_d;
            sum_q            <= sum_d;
            rem_q            <= rem_d;
            div_cnt_q        <= div_cnt_d;
            centroid_q       <= centroid_d;
            proximity_q      <= proximity_d;
            centroid_valid_q <= centroid_valid_d;
        end
    end

    assign centroid       = centroid_q;
    assign proximity      = proximity_q;
    assign centroid_valid = centroid_valid_q;

endmodule

// File: tb/tb_color_centroid.sv
// tb/tb_color_centroid.sv - self-checking bench for color_centroid
module tb_color_centroid;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        pxl_valid;
    logic [11:0] pxl_data;
    logic [2:0]  rgbfilter;
    logic [7:0]  centroid;
    logic [2:0]  proximity;
    logic        centroid_valid;
    logic        busy;

    color_centroid dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .pxl_valid      (pxl_valid),
        .pxl_data       (pxl_data),
        .rgbfilter      (rgbfilter),
        .centroid       (centroid),
        .proximity      (proximity),
        .centroid_valid (centroid_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int m_count, m_sum;
    int win_lo, win_hi;

    always @(negedge clk) if (centroid_valid) valid_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit match(input logic [11:0] p, input logic [2:0] f);
        return {p[11:8] >= 4'd8, p[7:4] >= 4'd8, p[3:0] >= 4'd8} == f;
    endfunction

    function automatic logic [11:0] pix(input int kind, input int r, input int c);
        case (kind)
            0: return 12'hF00;
            1: return (c == 75) ? 12'hF00 : 12'h000;
            2: return (c == 5 && r < 10) ? 12'hF00 : 12'h000;
            3: return (c < 40) ? 12'h0F0 : 12'h000;
            4: return 12'hFFF;
            6: return (c >= win_lo && c <= win_hi && $urandom_range(3) != 0)
                      ? (12'hF00 | (12'($urandom) & 12'h077)) : (12'($urandom) & 12'h777);
            default: return 12'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] exp_cent(input int cnt, input int sum);
        if (cnt < 16) return 8'h00;
        return 8'(1 << ((sum / cnt) / 10));
    endfunction

    function automatic int exp_prox(input int cnt);
        return (cnt / 600 > 7) ? 7 : cnt / 600;
    endfunction

    // returns just after the edge that accepts the last pixel fed
    task automatic feed(input int kind, input logic [2:0] filt, input int npx, input bit gaps);
        @(negedge clk);
        frame_start = 1'b1;
        pxl_valid   = 1'b0;
        rgbfilter   = filt;
        m_count     = 0;
        m_sum       = 0;
        for (int i = 0; i < npx; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                @(negedge clk);
                frame_start = 1'b0;
                pxl_valid   = 1'b0;
                pxl_data    = 12'($urandom);
            end
            @(negedge clk);
            frame_start = 1'b0;
            pxl_valid   = 1'b1;
            if (kind == 5 && i == 2400) rgbfilter = 3'($urandom);
            pxl_data = pix(kind, i / 80, i % 80);
            if (match(pxl_data, rgbfilter)) begin
                m_count++;
                m_sum += i % 80;
            end
        end
        @(posedge clk);
        #1 pxl_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input logic [7:0] ec, input int ep);
        int lat;
        int vb;
        vb  = valid_cnt;
        lat = 0;
        chk({tag, "_busy"}, int'(busy), 1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (centroid_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 21);
        chk({tag, "_centroid"}, int'(centroid), int'(ec));
        chk({tag, "_proximity"}, int'(proximity), ep);
        @(posedge clk);
        #1;
        chk({tag, "_valid_width"}, int'(centroid_valid), 0);
        chk({tag, "_busy_idle"}, int'(busy), 0);
        chk({tag, "_pulses"}, valid_cnt - vb, 1);
    endtask

    typedef struct {
        int         kind;
        logic [2:0] filt;
        logic [7:0] cent;
        int         prox;
    } vec_t;

    vec_t tbl[5];
    int   vb;

    initial begin
        tbl[0] = '{0, 3'b100, 8'b00001000, 7};
        tbl[1] = '{1, 3'b100, 8'b10000000, 0};
        tbl[2] = '{2, 3'b100, 8'b00000000, 0};
        tbl[3] = '{3, 3'b010, 8'b00000010, 4};
        tbl[4] = '{3, 3'b100, 8'b00000000, 0};

        rst         = 1'b1;
        frame_start = 1'b0;
        pxl_valid   = 1'b0;
        pxl_data    = 12'h000;
        rgbfilter   = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_centroid", int'(centroid), 0);
        chk("rst_proximity", int'(proximity), 0);
        chk("rst_valid", int'(centroid_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            feed(tbl[t].kind, tbl[t].filt, 4800, 1'b0);
            finish_frame($sformatf("vec%0d", t), tbl[t].cent, tbl[t].prox);
            chk($sformatf("vec%0d_model", t), int'(centroid), int'(exp_cent(m_count, m_sum)));
        end

        // partial frame abandoned by a new frame_start
        vb = valid_cnt;
        feed(4, 3'b111, 2000, 1'b0);
        feed(4, 3'b111, 4800, 1'b0);
        finish_frame("abort", 8'b00001000, 7);
        chk("abort_one_pulse", valid_cnt - vb, 1);

        // reset during division
        vb = valid_cnt;
        feed(0, 3'b100, 4800, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_centroid", int'(centroid), 0);
        chk("midrst_proximity", int'(proximity), 0);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_pulse", valid_cnt - vb, 0);
        chk("midrst_centroid_held", int'(centroid), 0);
        feed(1, 3'b100, 4800, 1'b0);
        finish_frame("after_rst", 8'b10000000, 0);

        // randomized frames against the reference model
        for (int r = 0; r < 4; r++) begin
            int kind;
            logic [2:0] f;
            kind   = (r % 2 == 0) ? 5 : 6;
            win_lo = $urandom_range(79);
            win_hi = win_lo + $urandom_range(79 - win_lo);
            f      = (kind == 6) ? 3'b100 : 3'($urandom);
            feed(kind, f, 4800, kind == 5);
            finish_frame($sformatf("rand%0d", r), exp_cent(m_count, m_sum), exp_prox(m_count));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
